// File: rtl/conway_life_monitor.sv
// Observer for the conway_life grid engine: counts generations and live cells and halts on
// extinction, still life, period-2 oscillation (built only with CONWAY_MON_OSC2_EN) or timeout.
module conway_life_monitor #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int GEN_W   = 16,
  parameter int MAX_GEN = 1000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [ROWS*COLS-1:0]             q,
  output logic [GEN_W-1:0]                 gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]   population,
  output logic                             extinct,
  output logic                             still,
  output logic                             osc2,
  output logic                             timeout,
  output logic                             done
);

  localparam int CELLS  = ROWS * COLS;
  localparam int PW     = $clog2(CELLS + 1);
  localparam int LEAVES = 1 << $clog2(CELLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [CELLS-1:0] prev1;
  logic [GEN_W-1:0] gen_d, gen_inc;
  logic [PW-1:0]    pop_d, pop_now;
  logic [CELLS-1:0] prev1_d;
  logic             extinct_d, still_d, timeout_d;
  logic             hit_extinct, hit_still, hit_osc2, hit_timeout;
  logic             flag_osc2, any_hit;
  logic             seed_en, shift_en;

  // Pairwise adder tree; every partial sum is bounded by CELLS, so PW bits never overflow.
  function automatic logic [PW-1:0] popcount(input logic [CELLS-1:0] v);
    logic [PW-1:0] t [LEAVES];
    for (int i = 0; i < LEAVES; i++) t[i] = '0;
    for (int i = 0; i < CELLS; i++)  t[i] = PW'(v[i]);
    for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) t[i] = t[2*i] + t[2*i+1];
    end
    return t[0];
  endfunction

  assign pop_now  = popcount(q);
  assign gen_inc  = gen_count + GEN_W'(1);
  assign seed_en  = !load && (state_q == S_ARM);
  assign shift_en = !load && (state_q == S_RUN);

  // Detection compares the incoming generation with the history before it shifts.
  assign hit_extinct = (q == '0);
  assign hit_still   = !hit_extinct && (q == prev1);
  assign flag_osc2   = !hit_extinct && hit_osc2;
  assign any_hit     = hit_extinct || hit_still || flag_osc2;
  assign hit_timeout = !any_hit && (gen_inc == GEN_W'(MAX_GEN));

`ifdef CONWAY_MON_OSC2_EN
  logic [CELLS-1:0] prev2;
  logic             p2_valid;

  assign hit_osc2 = p2_valid && (q != prev1) && (q == prev2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev2    <= '0;
      p2_valid <= 1'b0;
      osc2     <= 1'b0;
    end else if (load) begin
      osc2 <= 1'b0;
    end else if (seed_en) begin
      p2_valid <= 1'b0;
      osc2     <= 1'b0;
    end else if (shift_en) begin
      prev2    <= prev1;
      p2_valid <= 1'b1;
      osc2     <= flag_osc2;
    end
  end
`else
  assign hit_osc2 = 1'b0;
  assign osc2     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Load wins over any detection on the same edge.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = S_ARM;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ARM:   state_d = S_RUN;
        S_RUN:   state_d = (any_hit || hit_timeout) ? S_HALT : S_RUN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path infers a latch.
    gen_d     = gen_count;
    pop_d     = population;
    prev1_d   = prev1;
    extinct_d = extinct;
    still_d   = still;
    timeout_d = timeout;
    if (load) begin
      gen_d     = '0;
      extinct_d = 1'b0;
      still_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ARM: begin
          prev1_d   = q;
          pop_d     = pop_now;
          gen_d     = '0;
          extinct_d = 1'b0;
          still_d   = 1'b0;
          timeout_d = 1'b0;
        end
        S_RUN: begin
          prev1_d   = q;
          pop_d     = pop_now;
          gen_d     = gen_inc;
          extinct_d = hit_extinct;
          still_d   = hit_still;
          timeout_d = hit_timeout;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the history register is cleared on reset too, so a stale grid can never match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_count  <= '0;
      population <= '0;
      prev1      <= '0;
      extinct    <= 1'b0;
      still      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values.
      gen_count  <= gen_d;
      population <= pop_d;
      prev1      <= prev1_d;
      extinct    <= extinct_d;
      still      <= still_d;
      timeout    <= timeout_d;
    end
  end

  assign done = extinct || still || osc2 || timeout;

endmodule

// File: tb/tb_conway_life_monitor.sv
// Randomised and directed bench for conway_life_monitor, checked against a history-list model.
module tb_conway_life_monitor;

  localparam int MAX_GEN = 5;
`ifdef CONWAY_MON_OSC2_EN
  localparam bit OSC_EN = 1'b1;
`else
  localparam bit OSC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] q;
  logic [15:0] gen_count;
  logic [4:0]  population;
  logic        extinct, still, osc2, timeout, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: generation history since the seed plus the expected observable outputs.
  logic [15:0] hist[$];
  int m_gen, m_pop;
  bit m_ext, m_still, m_osc, m_to, m_run;

  conway_life_monitor #(
    .ROWS(4), .COLS(4), .GEN_W(16), .MAX_GEN(MAX_GEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .q(q),
    .gen_count(gen_count), .population(population),
    .extinct(extinct), .still(still), .osc2(osc2),
    .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".gen"},     32'(gen_count), 32'(m_gen));
    check({tag, ".extinct"}, 32'(extinct),   32'(m_ext));
    check({tag, ".still"},   32'(still),     32'(m_still));
    check({tag, ".osc2"},    32'(osc2),      32'(m_osc));
    check({tag, ".timeout"}, 32'(timeout),   32'(m_to));
    check({tag, ".done"},    32'(done),      32'(m_ext | m_still | m_osc | m_to));
  endtask

  task automatic check_all(input string tag);
    check_flags(tag);
    check({tag, ".pop"}, 32'(population), 32'(m_pop));
  endtask

  task automatic model_clear();
    hist.delete();
    m_gen = 0; m_pop = 0;
    m_ext = 0; m_still = 0; m_osc = 0; m_to = 0; m_run = 0;
  endtask

  task automatic model_step(input logic [15:0] v);
    int k;
    if (!m_run) return;
    k = hist.size();
    m_gen++;
    m_pop = $countones(v);
    if (v == 16'h0)                                   m_ext = 1;
    else if (v == hist[k-1])                          m_still = 1;
    else if (OSC_EN && k >= 2 && v == hist[k-2])      m_osc = 1;
    else if (m_gen == MAX_GEN)                        m_to = 1;
    hist.push_back(v);
    if (m_ext || m_still || m_osc || m_to) m_run = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [15:0] v, input string tag);
    q = v;
    tick();
    model_step(v);
    check_all(tag);
  endtask

  // Holds load for n edges with the seed on q, then lets the monitor capture it.
  task automatic do_load(input logic [15:0] seed, input int n, input string tag);
    load = 1'b1;
    q    = seed;
    repeat (n) tick();
    m_gen = 0; m_ext = 0; m_still = 0; m_osc = 0; m_to = 0; m_run = 0;
    check_flags({tag, ".arm"});
    load = 1'b0;
    tick();
    hist.delete();
    hist.push_back(seed);
    m_pop = $countones(seed);
    m_run = 1;
    check_all({tag, ".seed"});
  endtask

  initial begin
    logic [15:0] v;
    int r, k, guard;
    rst_n = 1'b0;
    load  = 1'b0;
    q     = 16'hFFFF;
    model_clear();
    repeat (2) tick();
    check_all("reset");

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(16'($urandom), "idle");

    // Still life, then held for 10 cycles while q wanders.
    do_load(16'h0660, 1, "still");
    step(16'h0660, "still.hit");
    check("still.flag", 32'(still), 32'd1);
    for (int i = 0; i < 10; i++) step(16'($urandom), "still.hold");

    do_load(16'h0007, 1, "ext");
    step(16'h0000, "ext.hit");

    // Blinker: period-2 detection, or timeout when the oscillator check is absent.
    do_load(16'h0222, 1, "osc");
    guard = 0;
    while (m_run && guard < 20) begin
      step((guard % 2 == 0) ? 16'h0070 : 16'h0222, "osc.run");
      guard++;
    end
    check("osc.halted", 32'(done), 32'd1);
    check("osc.gen", 32'(gen_count), OSC_EN ? 32'd2 : 32'(MAX_GEN));

    do_load(16'h0001, 1, "to");
    v = 16'h0002;
    for (int i = 0; i < MAX_GEN; i++) begin
      step(v, "to.run");
      v = v << 1;
    end
    check("to.flag", 32'(timeout), 32'd1);

    // Asynchronous reset in the middle of RUN.
    do_load(16'h0001, 1, "rst");
    step(16'h0002, "rst.run");
    step(16'h0004, "rst.run");
    step(16'h0008, "rst.run");
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all("rst.async");
    #2 rst_n = 1'b1;
    step(16'h0660, "rst.idle");

    // Re-arm out of HALT, then load over a would-be detection in RUN, then a long load.
    do_load(16'h0660, 1, "rearm");
    step(16'h0660, "rearm.halt");
    do_load(16'h0660, 1, "rearm2");
    do_load(16'h0660, 1, "ldprio");
    do_load(16'h0180, 3, "longload");
    step(16'h0180, "longload.hit");

    // Random episodes biased toward repeats so every terminal condition occurs.
    for (int e = 0; e < 40; e++) begin
      do_load(16'($urandom), 1 + int'($urandom_range(0, 1)), "rnd");
      guard = 0;
      while (m_run && guard < 2 * MAX_GEN) begin
        r = int'($urandom_range(0, 9));
        k = hist.size();
        if (r == 0)                 v = 16'h0;
        else if (r <= 2)            v = hist[k-1];
        else if (r <= 4 && k >= 2)  v = hist[k-2];
        else                        v = 16'($urandom);
        step(v, "rnd.run");
        guard++;
      end
      check("rnd.done", 32'(done), 32'd1);
      step(16'($urandom), "rnd.hold");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
